// File: rtl/tdc_pkg.sv
// Shared types and helpers for the counter-based TDC.
// Combinational helpers only; no latency, no backpressure.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } tdc_state_t;

  typedef struct packed {
    logic signed [31:0] value;
    logic               sat;
  } sat_res_t;

  // Clamp a signed value to the two's-complement range of nbit bits.
  function automatic sat_res_t sat_signed(input logic signed [31:0] value, input int nbit);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    sat_res_t           r;
    hi      = (32'sd1 <<< (nbit - 1)) - 32'sd1;
    lo      = -(32'sd1 <<< (nbit - 1));
    r.value = value;
    r.sat   = 1'b0;
    if (value > hi) begin
      r.value = hi;
      r.sat   = 1'b1;
    end else if (value < lo) begin
      r.value = lo;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_counter_ch.sv
// One TDC channel: lead/lag FSM, delay counter, averaging accumulator, output regs.
// Result registered one cycle after the closing event; no backpressure.
module tdc_counter_ch
  import tdc_pkg::*;
#(
  parameter int NBIT     = 4,
  parameter int CNT_W    = 8,
  parameter int TMAX     = 7,
  parameter int AVG_LOG2 = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en_i,
  input  logic                   ref_evt_i,
  input  logic                   fb_evt_i,
  output logic signed [NBIT-1:0] code_o,
  output logic                   code_valid_o,
  output logic                   code_sat_o
);

  localparam int AW   = CNT_W + AVG_LOG2;
  localparam int SC_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  // With AVG_LOG2 = 0 the last-sample index is 0, so every sample closes a window.
  localparam logic [SC_W-1:0]         SC_LAST = SC_W'((1 << AVG_LOG2) - 1);
  localparam logic signed [CNT_W-1:0] TMAX_C  = CNT_W'(TMAX);
  localparam logic signed [CNT_W-1:0] ONE_C   = CNT_W'(1);

  tdc_state_t              state_q, state_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [SC_W-1:0]         scnt_q, scnt_d;
  logic                    tmo_q, tmo_d;
  logic signed [NBIT-1:0]  code_q, code_d;
  logic                    vld_q, vld_d;
  logic                    sat_q, sat_d;

  logic                    emit;
  logic                    smp_tmo;
  logic signed [CNT_W-1:0] smp;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    avg;
  sat_res_t                sr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    smp     = '0;
    smp_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_evt_i && fb_evt_i) begin
          emit = 1'b1;
        end else if (ref_evt_i) begin
          state_d = LEAD_REF;
          cnt_d   = ONE_C;
        end else if (fb_evt_i) begin
          state_d = LEAD_FB;
          cnt_d   = ONE_C;
        end
      end
      LEAD_REF: begin
        if (fb_evt_i) begin
          emit = 1'b1;
          smp  = cnt_q;
          if (ref_evt_i) begin
            cnt_d = ONE_C;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (ref_evt_i) begin
          cnt_d = ONE_C;
        end else if (cnt_q >= TMAX_C) begin
          emit    = 1'b1;
          smp     = TMAX_C;
          smp_tmo = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      LEAD_FB: begin
        if (ref_evt_i) begin
          emit = 1'b1;
          smp  = -cnt_q;
          if (fb_evt_i) begin
            cnt_d = ONE_C;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (fb_evt_i) begin
          cnt_d = ONE_C;
        end else if (cnt_q >= TMAX_C) begin
          emit    = 1'b1;
          smp     = -TMAX_C;
          smp_tmo = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      emit    = 1'b0;
      smp_tmo = 1'b0;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    scnt_d = scnt_q;
    tmo_d  = tmo_q;
    code_d = code_q;
    vld_d  = 1'b0;
    sat_d  = sat_q;
    sum    = acc_q + AW'(smp);
    avg    = sum >>> AVG_LOG2;
    sr     = sat_signed(32'(avg), NBIT);
    if (emit) begin
      if (scnt_q == SC_LAST) begin
        code_d = NBIT'(sr.value);
        vld_d  = 1'b1;
        sat_d  = sr.sat | tmo_q | smp_tmo;
        acc_d  = '0;
        scnt_d = '0;
        tmo_d  = 1'b0;
      end else begin
        acc_d  = sum;
        scnt_d = scnt_q + SC_W'(1);
        tmo_d  = tmo_q | smp_tmo;
      end
    end
    if (!en_i) begin
      acc_d  = '0;
      scnt_d = '0;
      tmo_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      scnt_q  <= '0;
      tmo_q   <= 1'b0;
      code_q  <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
    end
  end

  assign code_o       = code_q;
  assign code_valid_o = vld_q;
  assign code_sat_o   = sat_q;

endmodule

// File: rtl/tdc_counter_multi.sv
// NCH independent counter TDC channels with packed outputs.
// One-cycle latency from closing event to code/code_valid; no backpressure.
module tdc_counter_multi #(
  parameter int NCH      = 1,
  parameter int NBIT     = 4,
  parameter int CNT_W    = 8,
  parameter int TMAX     = 7,
  parameter int AVG_LOG2 = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [NCH-1:0]        ref_evt,
  input  logic [NCH-1:0]        fb_evt,
  output logic [NCH*NBIT-1:0]   code,
  output logic [NCH-1:0]        code_valid,
  output logic [NCH-1:0]        code_sat
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    tdc_counter_ch #(
      .NBIT     (NBIT),
      .CNT_W    (CNT_W),
      .TMAX     (TMAX),
      .AVG_LOG2 (AVG_LOG2)
    ) u_ch (
      .clk          (clk),
      .rstn         (rstn),
      .en_i         (en),
      .ref_evt_i    (ref_evt[k]),
      .fb_evt_i     (fb_evt[k]),
      .code_o       (code[k*NBIT +: NBIT]),
      .code_valid_o (code_valid[k]),
      .code_sat_o   (code_sat[k])
    );
  end

endmodule

// File: tb/tb_tdc_counter_multi.sv
// Bench for tdc_counter_multi: four configurations share clock, reset and enable.
// Channel map: 0 default, 1 TMAX=20, 2 AVG_LOG2=2, 3..4 NCH=2.
module tb_tdc_counter_multi;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b1;
  logic [4:0] ev_ref = '0;
  logic [4:0] ev_fb = '0;
  wire [19:0] all_code;
  wire [4:0]  all_vld;
  wire [4:0]  all_sat;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tdc_counter_multi u_def (
    .clk(clk), .rstn(rstn), .en(en), .ref_evt(ev_ref[0]), .fb_evt(ev_fb[0]),
    .code(all_code[3:0]), .code_valid(all_vld[0]), .code_sat(all_sat[0]));

  tdc_counter_multi #(.TMAX(20)) u_tmx (
    .clk(clk), .rstn(rstn), .en(en), .ref_evt(ev_ref[1]), .fb_evt(ev_fb[1]),
    .code(all_code[7:4]), .code_valid(all_vld[1]), .code_sat(all_sat[1]));

  tdc_counter_multi #(.AVG_LOG2(2)) u_avg (
    .clk(clk), .rstn(rstn), .en(en), .ref_evt(ev_ref[2]), .fb_evt(ev_fb[2]),
    .code(all_code[11:8]), .code_valid(all_vld[2]), .code_sat(all_sat[2]));

  tdc_counter_multi #(.NCH(2)) u_two (
    .clk(clk), .rstn(rstn), .en(en), .ref_evt(ev_ref[4:3]), .fb_evt(ev_fb[4:3]),
    .code(all_code[19:12]), .code_valid(all_vld[4:3]), .code_sat(all_sat[4:3]));

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int sc(input logic [3:0] v);
    return int'($signed(v));
  endfunction

  // Model: timestamps of the leading event, delays by subtraction,
  // averages by floor division over a sample window.
  int tmax_p [5] = '{7, 20, 7, 7, 7};
  int avg_n  [5] = '{1, 1, 4, 1, 1};
  int lead   [5];
  int t0     [5];
  int acc    [5];
  int nsmp   [5];
  bit tmo    [5];
  int exp_code [5];
  bit exp_vld  [5];
  bit exp_sat  [5];
  int cyc = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 5; k++) begin
        lead[k] = 0; acc[k] = 0; nsmp[k] = 0; tmo[k] = 0;
        exp_code[k] = 0; exp_vld[k] = 0; exp_sat[k] = 0;
      end
    end else begin
      for (int k = 0; k < 5; k++) begin
        bit r, f, have, to, s8;
        int s, d, q;
        r = ev_ref[k]; f = ev_fb[k]; have = 0; to = 0; s = 0;
        exp_vld[k] = 0;
        if (!en) begin
          lead[k] = 0; acc[k] = 0; nsmp[k] = 0; tmo[k] = 0;
        end else begin
          d = cyc - t0[k];
          if (lead[k] == 0) begin
            if (r && f) have = 1;
            else if (r) begin lead[k] = 1; t0[k] = cyc; end
            else if (f) begin lead[k] = 2; t0[k] = cyc; end
          end else if (lead[k] == 1) begin
            if (f) begin
              have = 1; s = d;
              if (r) t0[k] = cyc; else lead[k] = 0;
            end else if (r) t0[k] = cyc;
            else if (d == tmax_p[k]) begin have = 1; s = tmax_p[k]; to = 1; lead[k] = 0; end
          end else begin
            if (r) begin
              have = 1; s = -d;
              if (f) t0[k] = cyc; else lead[k] = 0;
            end else if (f) t0[k] = cyc;
            else if (d == tmax_p[k]) begin have = 1; s = -tmax_p[k]; to = 1; lead[k] = 0; end
          end
          if (have) begin
            acc[k] += s; nsmp[k]++; tmo[k] |= to;
            if (nsmp[k] == avg_n[k]) begin
              q = acc[k] / avg_n[k];
              if (acc[k] < 0 && (acc[k] % avg_n[k]) != 0) q--;
              s8 = tmo[k];
              if (q > 7) begin q = 7; s8 = 1; end
              if (q < -8) begin q = -8; s8 = 1; end
              exp_code[k] = q; exp_sat[k] = s8; exp_vld[k] = 1;
              acc[k] = 0; nsmp[k] = 0; tmo[k] = 0;
            end
          end
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ch%0d valid", k), int'(all_vld[k]), int'(exp_vld[k]));
      chk($sformatf("ch%0d code", k), sc(all_code[k*4 +: 4]), exp_code[k]);
      chk($sformatf("ch%0d sat", k), int'(all_sat[k]), int'(exp_sat[k]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [4:0] r, input logic [4:0] f);
    ev_ref = r;
    ev_fb  = f;
    @(negedge clk);
    ev_ref = '0;
    ev_fb  = '0;
  endtask

  // Positive d: ref leads fb by d cycles; negative: fb leads ref.
  task automatic meas(input logic [4:0] m, input int d);
    if (d > 0) begin
      pulse(m, '0); tick(d - 1); pulse('0, m);
    end else begin
      pulse('0, m); tick(-d - 1); pulse(m, '0);
    end
  endtask

  initial begin
    #1 rstn = 1'b0;
    tick(3);
    chk("reset code", sc(all_code[3:0]), 0);
    chk("reset valid", int'(all_vld[0]), 0);
    chk("reset sat", int'(all_sat[0]), 0);
    rstn = 1'b1;
    tick(4);

    meas(5'b00001, 3);
    chk("lead3 code", sc(all_code[3:0]), 3);
    chk("lead3 valid", int'(all_vld[0]), 1);
    chk("lead3 sat", int'(all_sat[0]), 0);
    tick(1);
    chk("lead3 strobe width", int'(all_vld[0]), 0);
    chk("lead3 code hold", sc(all_code[3:0]), 3);

    tick(3);
    meas(5'b00001, -2);
    chk("lag2 code", sc(all_code[3:0]), -2);
    tick(3);
    pulse(5'b00001, 5'b00001);
    chk("both code", sc(all_code[3:0]), 0);
    chk("both valid", int'(all_vld[0]), 1);

    tick(3);
    pulse(5'b00001, '0);
    tick(6);
    chk("timeout early valid", int'(all_vld[0]), 0);
    tick(1);
    chk("timeout code", sc(all_code[3:0]), 7);
    chk("timeout sat", int'(all_sat[0]), 1);
    chk("timeout valid", int'(all_vld[0]), 1);

    tick(2);
    meas(5'b00010, 12);
    chk("clamp code", sc(all_code[7:4]), 7);
    chk("clamp sat", int'(all_sat[1]), 1);
    tick(2);
    meas(5'b00010, -5);
    chk("tmax20 lag5", sc(all_code[7:4]), -5);

    tick(2);
    meas(5'b00100, 1); chk("avg mid1", int'(all_vld[2]), 0); tick(1);
    meas(5'b00100, 2); chk("avg mid2", int'(all_vld[2]), 0); tick(1);
    meas(5'b00100, 2); chk("avg mid3", int'(all_vld[2]), 0); tick(1);
    meas(5'b00100, 3);
    chk("avg pos code", sc(all_code[11:8]), 2);
    chk("avg pos valid", int'(all_vld[2]), 1);
    tick(1);
    meas(5'b00100, -1); tick(1);
    meas(5'b00100, -1); tick(1);
    meas(5'b00100, -1); tick(1);
    meas(5'b00100, -2);
    chk("avg neg code", sc(all_code[11:8]), -2);
    chk("avg neg sat", int'(all_sat[2]), 0);

    tick(2);
    pulse(5'b01000, '0);
    pulse('0, 5'b10000);
    pulse(5'b10000, '0);
    chk("two ch1 code", sc(all_code[19:16]), -1);
    chk("two ch0 quiet", int'(all_vld[3]), 0);
    pulse('0, 5'b01000);
    chk("two ch0 code", sc(all_code[15:12]), 3);
    chk("two ch1 hold", sc(all_code[19:16]), -1);

    tick(2);
    pulse(5'b00001, '0);
    tick(2);
    rstn = 1'b0;
    tick(1);
    chk("midrst code", sc(all_code[3:0]), 0);
    chk("midrst other code", sc(all_code[7:4]), 0);
    rstn = 1'b1;
    tick(2);
    meas(5'b00001, -3);
    chk("post rst code", sc(all_code[3:0]), -3);
    chk("post rst valid", int'(all_vld[0]), 1);

    tick(2);
    pulse(5'b00001, '0);
    tick(2);
    en = 1'b0;
    tick(3);
    chk("en low valid", int'(all_vld[0]), 0);
    chk("en low hold", sc(all_code[3:0]), -3);
    en = 1'b1;
    ev_fb = 5'b00001;
    tick(1);
    ev_fb = '0;
    chk("en rise no stale", int'(all_vld[0]), 0);
    tick(1);
    pulse(5'b00001, '0);
    chk("en rise accepted", sc(all_code[3:0]), -2);

    tick(10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tdc_counter_multi.md
# tdc_counter_multi

Synthesizable, multi-channel, counter-based time-to-digital converter: the clocked successor to the ideal phase-detector TDC model. Each channel measures the signed delay, in `clk` cycles, between a reference event and a feedback event, with optional averaging, saturation and timeout. Output is a signed `NBIT` code per channel with a valid strobe. It sits in the digital PLL/neuron loop, ahead of the loop filter.

## Interface
- `NCH`, 1: number of independent channels
- `NBIT`, 4: output code width, two's complement
- `CNT_W`, 8: internal signed sample/counter width
- `TMAX`, 7: timeout in cycles; requires 1 ≤ `TMAX` < 2^(`CNT_W`-1)
- `AVG_LOG2`, 0: average over 2^`AVG_LOG2` samples; 0 disables averaging
- `clk`  in  1  sole clock
- `rstn`  in  1  asynchronous, active-low reset
- `en`  in  1  global enable; low forces every channel idle and clears its accumulator
- `ref_evt`  in  `NCH`  single-cycle reference event pulses, synchronous to `clk`
- `fb_evt`  in  `NCH`  single-cycle feedback event pulses, synchronous to `clk`
- `code`  out  `NCH*NBIT`  signed result; channel k occupies `[k*NBIT +: NBIT]`
- `code_valid`  out  `NCH`  one-cycle strobe when `code` for that channel updates
- `code_sat`  out  `NCH`  set with `code_valid` when the result was clamped or timed out

## Operation
- Channels are fully independent. Per-channel FSM states are IDLE, LEAD_REF and LEAD_FB. The counter `cnt` is `CNT_W` bits wide.
- **IDLE**
  - `ref_evt` and `fb_evt` together: emit sample 0 and stay in IDLE.
  - `ref_evt` only: set `cnt`=1 and go to LEAD_REF.
  - `fb_evt` only: set `cnt`=1 and go to LEAD_FB.
- **LEAD_REF**
  - `fb_evt` closes the measurement and emits sample +`cnt`.
    - With a simultaneous `ref_evt`: next state is LEAD_REF with `cnt`=1.
    - Otherwise: next state is IDLE.
  - `ref_evt` alone (second lead): the measurement is discarded, no sample is emitted, `cnt` is set to 1 and the state stays LEAD_REF.
  - Neither event: `cnt`++. When `cnt` would exceed `TMAX`, emit sample +`TMAX` flagged timeout and go to IDLE.
- **LEAD_FB**: mirror image of LEAD_REF with `ref_evt`/`fb_evt` swapped and the sample negated (−`cnt`, −`TMAX`). Positive code means feedback lags reference.
- **Averaging**
  - Each emitted sample is added to a signed accumulator of width `CNT_W`+`AVG_LOG2`. A sample counter of width `AVG_LOG2` tracks how many have been added.
  - On the 2^`AVG_LOG2`-th sample, the result is the accumulator shifted right arithmetically by `AVG_LOG2` (floor). The accumulator and sample counter then clear.
  - With `AVG_LOG2`=0, every sample is a result.
- **Saturation**
  - The result is clamped to [−2^(`NBIT`-1), 2^(`NBIT`-1)−1].
  - `code_sat`=1 if clamping occurred or any sample in the averaging window was a timeout.
- **Enable**: `en` low returns every FSM to IDLE and clears `cnt`, the accumulator, the sample counter and the timeout flag. `code` holds its last value. No `code_valid` is produced while `en` is low.

## Timing
- Reset values (asynchronous on `rstn` low): `code`=0, `code_valid`=0, `code_sat`=0, FSM in IDLE, all counters 0.
- Latency: the closing event in cycle N produces `code`, `code_valid` and `code_sat` registered in cycle N+1.
- `code_valid` is high for exactly one cycle per result. `code` is stable until the next strobe.
- Measured delay equals the number of `clk` edges between the two events. Events in adjacent cycles give ±1.
- Reset asserted mid-measurement aborts the measurement. After release the channel waits in IDLE for a fresh event.
- Events arriving in the cycle `en` rises are accepted.

## Structure
- Package `tdc_pkg`:
  - `tdc_state_t` enum (IDLE, LEAD_REF, LEAD_FB)
  - function `sat_signed(value, NBIT)` returning the clamped value and a sat flag
- Sub-module `tdc_counter_ch`: one channel, containing the FSM, counter, accumulator and output registers.
- Top `tdc_counter_multi` instantiates `NCH` copies in a generate loop and packs the outputs.

## Test plan
- Defaults, `ref_evt` at cycle 10 and `fb_evt` at cycle 13 → `code`=+3, `code_sat`=0, `code_valid` high at cycle 14 only.
- `fb_evt` at cycle 20 and `ref_evt` at cycle 22 → `code`=−2. Both events at cycle 30 → `code`=0 at cycle 31.
- `ref_evt` with no `fb_evt` → `code`=+7, `code_sat`=1 seven cycles later.
- `TMAX`=20, 12-cycle lead → `code`=+7, `code_sat`=1 (clamped).
- `AVG_LOG2`=2, samples +1,+2,+2,+3 → single `code`=+2. Samples −1,−1,−1,−2 → `code`=−2 (floor of −1.25). No valid strobes on intermediate samples.
- `NCH`=2: ch0 pair with +3 delay and ch1 pair with −1 delay interleaved → independent correct codes.
- Reset mid-measurement: `rstn` pulsed low mid-LEAD_REF → outputs 0, and no valid until a new complete pair.
- Enable mid-measurement: `en` dropped mid-LEAD_REF → no valid, and no stale result after `en` returns high.
